// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encoding and index-width helper shared by the intersection controller
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2,
        PH_FLASH  = 2'd3
    } phase_e;

    // Never returns less than 1, so a two-approach build still gets a 1-bit index.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_next_dir.sv
// rtl/rr_next_dir.sv - round-robin search for the next pending approach after the current one
module rr_next_dir #(
    parameter int NUM_DIR = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_DIR-1:0] pending_i,
    input  logic [IW-1:0]      cur_i,
    output logic [IW-1:0]      next_o,
    output logic               found_o
);

    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest pending approach is the last one written.
    always_comb begin
        next_o  = cur_i;
        found_o = 1'b0;
        idx     = cur_i;
        for (int off = NUM_DIR; off >= 1; off--) begin
            idx = IW'((int'(cur_i) + off) % NUM_DIR);
            if (pending_i[idx]) begin
                found_o = 1'b1;
                next_o  = idx;
            end
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - round-robin intersection controller with tick-timed phases and night flash
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR   = 4,
    parameter int TW        = 8,
    parameter int GREEN_MIN = 4,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int FLASH_T   = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [NUM_DIR-1:0]          req,
    input  logic                        night,
    output logic [NUM_DIR-1:0]          red,
    output logic [NUM_DIR-1:0]          yellow,
    output logic [NUM_DIR-1:0]          green,
    output logic [clog2(NUM_DIR)-1:0]   active_dir,
    output logic [1:0]                  phase
);

    localparam int                 IW  = clog2(NUM_DIR);
    localparam logic [NUM_DIR-1:0] ONE = NUM_DIR'(1);

    phase_e             phase_q, phase_d;
    logic [IW-1:0]      active_q, active_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NUM_DIR-1:0] pending_q, pending_d;
    logic [NUM_DIR-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
    logic               flash_q, flash_d;
    logic               after_flash_q, after_flash_d;

    logic [IW-1:0]      rr_next;
    logic               rr_found;
    logic               expiry;
    logic [NUM_DIR-1:0] foreign;
    logic [NUM_DIR-1:0] active_mask;

    rr_next_dir #(
        .NUM_DIR (NUM_DIR),
        .IW      (IW)
    ) u_rr (
        .pending_i (pending_q),
        .cur_i     (active_q),
        .next_o    (rr_next),
        .found_o   (rr_found)
    );

    always_comb begin
        phase_d       = phase_q;
        active_d      = active_q;
        flash_d       = flash_q;
        after_flash_d = after_flash_q;
        pending_d     = pending_q | req;
        expiry        = tick && (timer_q == '0);
        foreign       = pending_q & ~(ONE << active_q);
        timer_d       = (tick && (timer_q != '0)) ? timer_q - TW'(1) : timer_q;

        case (phase_q)
            PH_GREEN: begin
                // With the minimum green served and no foreign demand the timer sits at zero: rest in green.
                if (tick && (night || ((timer_q == '0) && (|foreign)))) begin
                    phase_d = PH_YELLOW;
                    timer_d = TW'(YELLOW_T - 1);
                end
            end
            PH_YELLOW: begin
                if (expiry) begin
                    phase_d = PH_ALLRED;
                    timer_d = TW'(ALLRED_T - 1);
                end
            end
            PH_ALLRED: begin
                if (expiry) begin
                    if (night) begin
                        phase_d       = PH_FLASH;
                        timer_d       = TW'(FLASH_T - 1);
                        flash_d       = 1'b1;
                        after_flash_d = 1'b0;
                    end else begin
                        phase_d       = PH_GREEN;
                        timer_d       = TW'(GREEN_MIN - 1);
                        after_flash_d = 1'b0;
                        if (after_flash_q) begin
                            active_d = '0;
                        end else if (rr_found) begin
                            active_d = rr_next;
                        end
                        // Clear beats a same-cycle set; a held request re-latches on the next clock.
                        pending_d = pending_d & ~(ONE << active_d);
                    end
                end
            end
            PH_FLASH: begin
                if (tick && !night) begin
                    phase_d       = PH_ALLRED;
                    timer_d       = TW'(ALLRED_T - 1);
                    after_flash_d = 1'b1;
                end else if (expiry) begin
                    flash_d = ~flash_q;
                    timer_d = TW'(FLASH_T - 1);
                end
            end
            default: begin
                phase_d = PH_GREEN;
            end
        endcase

        active_mask = ONE << active_d;
        green_d     = '0;
        yellow_d    = '0;
        red_d       = '0;
        case (phase_d)
            PH_GREEN: begin
                green_d = active_mask;
                red_d   = ~active_mask;
            end
            PH_YELLOW: begin
                yellow_d = active_mask;
                red_d    = ~active_mask;
            end
            PH_ALLRED: begin
                red_d = '1;
            end
            PH_FLASH: begin
                yellow_d = {NUM_DIR{flash_d}};
            end
            default: begin
                red_d = '1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q       <= PH_GREEN;
            active_q      <= '0;
            timer_q       <= TW'(GREEN_MIN - 1);
            pending_q     <= '0;
            flash_q       <= 1'b0;
            after_flash_q <= 1'b0;
            green_q       <= ONE;
            red_q         <= ~ONE;
            yellow_q      <= '0;
        end else begin
            phase_q       <= phase_d;
            active_q      <= active_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            flash_q       <= flash_d;
            after_flash_q <= after_flash_d;
            green_q       <= green_d;
            red_q         <= red_d;
            yellow_q      <= yellow_d;
        end
    end

    assign red        = red_q;
    assign yellow     = yellow_q;
    assign green      = green_q;
    assign active_dir = active_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb/tb_traffic_intersection_ctrl.sv - scoreboard bench for traffic_intersection_ctrl against a tick-counting reference model
module tb_traffic_intersection_ctrl;

    localparam int N         = 4;
    localparam int GREEN_MIN = 4;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int FLASH_T   = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       night;
    logic [3:0] req;
    logic [3:0] red, yellow, green;
    logic [1:0] active_dir, phase;

    traffic_intersection_ctrl #(
        .NUM_DIR   (N),
        .TW        (8),
        .GREEN_MIN (GREEN_MIN),
        .YELLOW_T  (YELLOW_T),
        .ALLRED_T  (ALLRED_T),
        .FLASH_T   (FLASH_T)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .req        (req),
        .night      (night),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .active_dir (active_dir),
        .phase      (phase)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] r;
        logic [1:0] dir;
        logic [1:0] ph;
        logic       rst;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: phase name, ticks still owed to the phase, latched demand.
    int       m_ph;
    int       m_dir;
    int       m_left;
    bit [3:0] m_pend;
    bit       m_flash;
    bit       m_after;

    int ph2[7];
    int ph5[8];
    int ye5[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_dir + k) % N;
            if (m_pend[j]) return j;
        end
        return m_dir;
    endfunction

    function automatic void model_step(bit r, bit t, bit [3:0] q, bit n);
        bit [3:0] nxt_pend;
        bit       done;
        bit       foreign;
        if (r) begin
            m_ph = 0; m_dir = 0; m_left = GREEN_MIN; m_pend = '0; m_flash = 0; m_after = 0;
            return;
        end
        nxt_pend = m_pend | q;
        done     = t && (m_left == 1);
        case (m_ph)
            0: begin
                foreign = 0;
                for (int j = 0; j < N; j++) if (j != m_dir && m_pend[j]) foreign = 1;
                if (t && (n || (m_left == 1 && foreign))) begin
                    m_ph = 1; m_left = YELLOW_T;
                end else if (t && m_left > 1) m_left--;
            end
            1: begin
                if (done) begin m_ph = 2; m_left = ALLRED_T; end
                else if (t) m_left--;
            end
            2: begin
                if (done) begin
                    if (n) begin
                        m_ph = 3; m_left = FLASH_T; m_flash = 1; m_after = 0;
                    end else begin
                        m_dir = m_after ? 0 : rr_pick();
                        m_ph = 0; m_left = GREEN_MIN; m_after = 0;
                        nxt_pend[m_dir] = 1'b0;
                    end
                end else if (t) m_left--;
            end
            default: begin
                if (t && !n) begin m_ph = 2; m_left = ALLRED_T; m_after = 1; end
                else if (done) begin m_flash = !m_flash; m_left = FLASH_T; end
                else if (t) m_left--;
            end
        endcase
        m_pend = nxt_pend;
    endfunction

    function automatic exp_t model_out(bit r);
        exp_t     e;
        bit [3:0] m;
        m     = 4'b0001 << m_dir;
        e.g   = 4'h0; e.y = 4'h0; e.r = 4'h0;
        e.dir = m_dir[1:0];
        e.ph  = m_ph[1:0];
        e.rst = r;
        case (m_ph)
            0:       begin e.g = m; e.r = ~m; end
            1:       begin e.y = m; e.r = ~m; end
            2:       e.r = 4'hF;
            default: e.y = m_flash ? 4'hF : 4'h0;
        endcase
        return e;
    endfunction

    task automatic step(input bit r, input bit t, input logic [3:0] q, input bit n);
        reset = r; tick = t; req = q; night = n;
        model_step(r, t, q, n);
        sb.push_back(model_out(r));
        @(posedge clock);
        #1;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [1:0] prev_ph;
        prev_ph = 2'd0;
        forever begin
            @(negedge clock);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("outputs", {green, yellow, red, active_dir, phase}, {e.g, e.y, e.r, e.dir, e.ph});
                check("green_onehot", ($countones(green) <= 1), 1);
                check("green_with_yellow", ((|green) && (|yellow)), 0);
                if (!e.rst && phase == 2'd0 && prev_ph != 2'd0)
                    check("green_entry_from_allred", prev_ph, 2'd2);
                if (!e.rst && phase == 2'd2 && prev_ph != 2'd2)
                    check("allred_entry_from_yellow_or_flash", (prev_ph == 2'd1 || prev_ph == 2'd3), 1);
                prev_ph = phase;
            end
        end
    end

    initial begin : stimulus
        int k, gcnt, ycnt, acnt;
        bit left_green, rn;
        logic [3:0] rq;
        ph2 = '{0, 0, 0, 1, 1, 2, 0};
        ph5 = '{1, 1, 2, 3, 3, 3, 3, 3};
        ye5 = '{1, 1, 0, 15, 15, 0, 0, 15};
        reset = 1'b1; tick = 1'b1; req = 4'h0; night = 1'b0;

        // Reset state, then rest in green with no demand.
        step(1, 1, 4'h0, 0);
        check("rst_green", green, 4'b0001);
        check("rst_red", red, 4'b1110);
        check("rst_yellow", yellow, 4'b0000);
        check("rst_phase", phase, 0);
        repeat (20) step(0, 1, 4'h0, 0);
        check("rest_phase", phase, 0);
        check("rest_dir", active_dir, 0);

        // Single pulse on approach 2.
        step(1, 1, 4'h0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, (i == 1) ? 4'b0100 : 4'b0000, 0);
            check("pulse2_phase", phase, ph2[i]);
        end
        check("pulse2_dir", active_dir, 2);
        check("pulse2_green", green, 4'b0100);

        // Reset while yellow on dir 2 with 0011 pending.
        step(0, 1, 4'b0011, 0);
        k = 0;
        while (phase != 2'd1 && k < 20) begin
            step(0, 1, 4'h0, 0);
            k++;
        end
        check("reach_yellow", phase, 1);
        step(1, 0, 4'h0, 0);
        check("midrst_green", green, 4'b0001);
        check("midrst_phase", phase, 0);
        repeat (10) step(0, 1, 4'h0, 0);
        check("midrst_pending_cleared", {active_dir, phase}, 4'b0000);

        // Two requests served in round-robin order from dir 0.
        step(1, 1, 4'h0, 0);
        for (int i = 0; i < 31; i++) begin
            step(0, 1, (i == 0) ? 4'b1010 : 4'b0000, 0);
            if (i == 6)  check("rr_first_dir1", active_dir, 1);
            if (i == 13) check("rr_second_dir3", active_dir, 3);
        end
        check("rr_rest_dir3", {active_dir, phase}, {2'd3, 2'd0});

        // Tick every third clock stretches each phase threefold.
        step(1, 1, 4'h0, 0);
        gcnt = 1; ycnt = 0; acnt = 0; left_green = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, (i % 3 == 2), (i == 0) ? 4'b0010 : 4'b0000, 0);
            if (phase == 2'd0 && !left_green) gcnt++;
            else begin
                left_green = 1;
                if (phase == 2'd1) ycnt++;
                if (phase == 2'd2) acnt++;
            end
        end
        check("slow_green_len", gcnt, 12);
        check("slow_yellow_len", ycnt, 6);
        check("slow_allred_len", acnt, 3);

        // Night mode entry, flashing, and exit back to approach 0.
        step(1, 1, 4'h0, 0);
        step(0, 1, 4'h0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 4'h0, 1);
            check("night_phase", phase, ph5[i]);
            check("night_yellow", yellow, ye5[i]);
        end
        step(0, 1, 4'h0, 0);
        check("day_allred", {phase, red}, {2'd2, 4'hF});
        step(0, 1, 4'h0, 0);
        check("day_green0", {phase, green}, {2'd0, 4'b0001});

        // Random traffic against the reference model.
        rn = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 199) == 0) rn = !rn;
            for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 699) == 0), $urandom_range(0, 1), rq, rn);
        end

        @(negedge clock);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
